reaction_timer_core: RTL and testbench
======================================

Name: reaction_timer_core

Overview:
- Parametrised reaction-time game engine: random arm delay, random one-hot LED target, BCD reaction count, best-score tracking.
- Adds false-start/fault reporting, timeout, and configurable LED count and BCD width.
- Sits between the top-level glue (KEY debounce/pulse, clock divider, 7-seg decoders) and the board LEDs/switches.
- All timing is counted in `tick` pulses (e.g. 1 ms) on `mclk`.

Parameters:
- NUM_LEDS, 10, number of target LEDs/switches (2..32).
- BCD_DIGITS, 4, digits of reaction count and best score.
- DELAY_BITS, 11, width of random arm-delay field.
- MIN_DELAY, 500, minimum arm delay in ticks.
- SHOW_TICKS, 2047, ticks a result or fault is held before returning to IDLE.
- LFSR_SEED, 16'hACE1, non-zero reset value of the internal 16-bit LFSR.

Ports:
- mclk, in, 1, clock.
- FSMreset, in, 1, reset; asynchronous, active-high.
- tick, in, 1, timebase enable, one mclk cycle wide.
- start, in, 1, one-cycle start pulse (already edge-detected).
- sw, in, NUM_LEDS, player switches, synchronous to mclk.
- led, out, NUM_LEDS, target LED drive (one-hot or zero).
- disp_bcd, out, 4*BCD_DIGITS, value for 7-seg: best in IDLE, reaction count otherwise.
- best_valid, out, 1, best score holds a real result.
- state_o, out, 3, current state encoding (debug).
- false_start, out, 1, last round ended by switch/start during ARMED.
- timeout, out, 1, last round saturated the counter.
- wrong_sw, out, 1, last round ended by a wrong switch (feature only; else tied 0).

Behaviour:
- Reset (async): state=IDLE; led=0; count=0; best=all 9s; best_valid=0; flags=0; LFSR=LFSR_SEED; shuffle=1 (bit 0).
- Regardless of state:
  - LFSR (x^16+x^14+x^13+x^11) advances every mclk.
  - Shuffle one-hot rotates left every mclk, wrapping bit NUM_LEDS-1 to bit 0.
- IDLE:
  - led=0; disp_bcd=best (all 9s until best_valid).
  - start -> ARMED; load delay_cnt = MIN_DELAY + LFSR[DELAY_BITS-1:0]; clear all flags; count=0.
- ARMED:
  - led=0; disp_bcd=0.
  - On tick, delay_cnt decrements.
  - Priority 1: any sw bit high or start -> FAULT, false_start=1.
  - Priority 2: delay_cnt==0 at a tick -> TIMING; led latched from shuffle in the same cycle; count=0.
- TIMING:
  - On tick, count increments as BCD (per-digit carry at 9).
  - |(sw & led) -> SHOWING; result=count of that cycle, excluding any tick in that same cycle.
  - Else if count==all 9s and tick -> SHOWING with timeout=1; count holds at all 9s.
  - A switch that is not on the target is ignored unless the feature is enabled.
- SHOWING:
  - Entry cycle: if !timeout && (!best_valid || result<best), then best=result and best_valid=1.
  - led=0; disp_bcd=result; show_cnt counts SHOW_TICKS ticks -> IDLE.
  - start is ignored.
- FAULT:
  - led=0; disp_bcd=all 9s; held SHOW_TICKS ticks -> IDLE; flags persist until the next start.
- Simultaneous events:
  - tick and hit in the same cycle: hit wins; count is not incremented.
  - Reset mid-round returns to IDLE and also clears best.
- Latency: led is asserted the cycle after the final delay tick; state changes are registered (one mclk).

Optional Feature:
- Macro WRONG_SWITCH_FAULT_EN.
- Defined: in TIMING, any sw bit high outside led -> FAULT with wrong_sw=1. If a correct and a wrong switch rise in the same cycle, wrong wins.
- Undefined: wrong switches are ignored and wrong_sw is constant 0.

Decomposition:
- Package reaction_pkg: state encodings (IDLE=0, ARMED=1, TIMING=2, SHOWING=3, FAULT=4), LFSR taps, default parameter values.
- Sub-module bcd_counter_n (BCD_DIGITS): inc, clr, saturate-at-all-9s, sat flag. Instantiated for count; the comparison for best is done by a whole-vector unsigned compare, which is valid for BCD.

Test Plan:
- Reset, then start; force LFSR[10:0]=0 via seed, MIN_DELAY=5 -> led goes one-hot exactly 1 cycle after the 5th tick; state_o=2.
- In TIMING, raise the matching sw after 123 ticks -> disp_bcd=16'h0123; best=0123; best_valid=1; IDLE after SHOW_TICKS ticks.
- Second round with hit at 200 ticks -> best stays 0123; a third round at 050 -> best=0050.
- sw[3] high during ARMED -> FAULT, false_start=1, led stays 0, best unchanged.
- BCD_DIGITS=2, no hit -> count stops at 8'h99, timeout=1, best not updated.
- With WRONG_SWITCH_FAULT_EN, raise a non-target sw in TIMING -> FAULT, wrong_sw=1. Without the macro -> round continues; the correct sw still scores.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared state encodings, LFSR definition and default parameters for the reaction timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_TIMING  = 3'd2,
    ST_SHOWING = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam int unsigned LFSR_W = 16;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned DEF_NUM_LEDS   = 10;
  localparam int unsigned DEF_BCD_DIGITS = 4;
  localparam int unsigned DEF_DELAY_BITS = 11;
  localparam int unsigned DEF_MIN_DELAY  = 500;
  localparam int unsigned DEF_SHOW_TICKS = 2047;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
  endfunction

endpackage

// File: rtl/reaction_timer_core_bcd.sv
// Multi-digit BCD up-counter with synchronous clear and saturation at all 9s.
module bcd_counter_n #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                mclk,
  input  logic                FSMreset,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [4*DIGITS-1:0] count_o,
  output logic                sat_o
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q;
  logic         carry;

  // Ripple the carry digit by digit; never wraps once saturated.
  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b1;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_q) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (carry) begin
          if (cnt_q[4*i +: 4] == 4'h9) begin
            cnt_d[4*i +: 4] = 4'h0;
          end else begin
            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'h1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge FSMreset) begin
    if (FSMreset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= (cnt_d == ALL9);
    end
  end

  assign count_o = cnt_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time game engine: random arm delay, one-hot target, BCD timing, best score.
// Optional wrong-switch fault in TIMING enabled by defining WRONG_SWITCH_FAULT_EN.
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int unsigned       NUM_LEDS   = DEF_NUM_LEDS,
  parameter int unsigned       BCD_DIGITS = DEF_BCD_DIGITS,
  parameter int unsigned       DELAY_BITS = DEF_DELAY_BITS,
  parameter int unsigned       MIN_DELAY  = DEF_MIN_DELAY,
  parameter int unsigned       SHOW_TICKS = DEF_SHOW_TICKS,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = DEF_LFSR_SEED
) (
  input  logic                    mclk,
  input  logic                    FSMreset,
  input  logic                    tick,
  input  logic                    start,
  input  logic [NUM_LEDS-1:0]     sw,
  output logic [NUM_LEDS-1:0]     led,
  output logic [4*BCD_DIGITS-1:0] disp_bcd,
  output logic                    best_valid,
  output logic [2:0]              state_o,
  output logic                    false_start,
  output logic                    timeout,
  output logic                    wrong_sw
);

  localparam int unsigned CW     = 4 * BCD_DIGITS;
  localparam int unsigned DLY_W  = $clog2(MIN_DELAY + (1 << DELAY_BITS));
  localparam int unsigned SHOW_W = (SHOW_TICKS < 2) ? 1 : $clog2(SHOW_TICKS + 1);
  localparam logic [CW-1:0] ALL9 = {BCD_DIGITS{4'h9}};

  state_e               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr_q;
  logic [NUM_LEDS-1:0]  shuffle_q;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic [DLY_W-1:0]     delay_q, delay_d;
  logic [SHOW_W-1:0]    show_q, show_d;
  logic [CW-1:0]        best_q, best_d;
  logic                 best_valid_q, best_valid_d;
  logic [CW-1:0]        disp_q, disp_d;
  logic                 fs_q, fs_d;
  logic                 to_q, to_d;
  logic [CW-1:0]        cnt;
  logic                 cnt_sat, cnt_clr, cnt_inc;
  logic                 hit;
`ifdef WRONG_SWITCH_FAULT_EN
  logic                 ws_q, ws_d;
  logic                 wrong;
`endif

  bcd_counter_n #(.DIGITS(BCD_DIGITS)) u_count (
    .mclk     (mclk),
    .FSMreset (FSMreset),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .count_o  (cnt),
    .sat_o    (cnt_sat)
  );

  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    delay_d      = delay_q;
    show_d       = show_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    fs_d         = fs_q;
    to_d         = to_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    hit          = |(sw & led_q);
`ifdef WRONG_SWITCH_FAULT_EN
    ws_d         = ws_q;
    wrong        = |(sw & ~led_q);
`endif

    unique case (state_q)
      ST_IDLE: begin
        led_d = '0;
        if (start) begin
          state_d = ST_ARMED;
          delay_d = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[DELAY_BITS-1:0]);
          fs_d    = 1'b0;
          to_d    = 1'b0;
`ifdef WRONG_SWITCH_FAULT_EN
          ws_d    = 1'b0;
`endif
          cnt_clr = 1'b1;
        end
      end

      // Early input beats delay expiry; the final tick latches the target.
      ST_ARMED: begin
        if ((|sw) || start) begin
          state_d = ST_FAULT;
          fs_d    = 1'b1;
          show_d  = SHOW_W'(SHOW_TICKS);
        end else if (tick) begin
          if (delay_q <= DLY_W'(1)) begin
            state_d = ST_TIMING;
            led_d   = shuffle_q;
            cnt_clr = 1'b1;
          end else begin
            delay_d = delay_q - DLY_W'(1);
          end
        end
      end

      ST_TIMING: begin
`ifdef WRONG_SWITCH_FAULT_EN
        if (wrong) begin
          state_d = ST_FAULT;
          ws_d    = 1'b1;
          led_d   = '0;
          show_d  = SHOW_W'(SHOW_TICKS);
        end else
`endif
        if (hit) begin
          state_d = ST_SHOWING;
          led_d   = '0;
          show_d  = SHOW_W'(SHOW_TICKS);
          if (!best_valid_q || (cnt < best_q)) begin
            best_d       = cnt;
            best_valid_d = 1'b1;
          end
        end else if (tick) begin
          if (cnt_sat) begin
            state_d = ST_SHOWING;
            to_d    = 1'b1;
            led_d   = '0;
            show_d  = SHOW_W'(SHOW_TICKS);
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_SHOWING, ST_FAULT: begin
        led_d = '0;
        if (tick) begin
          if (show_q <= SHOW_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            show_d = show_q - SHOW_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = '0;
      end
    endcase

    unique case (state_q)
      ST_IDLE:               disp_d = best_q;
      ST_ARMED:              disp_d = '0;
      ST_TIMING, ST_SHOWING: disp_d = cnt;
      default:               disp_d = ALL9;
    endcase
  end

  always_ff @(posedge mclk or posedge FSMreset) begin
    if (FSMreset) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_SEED;
      shuffle_q    <= NUM_LEDS'(1);
      led_q        <= '0;
      delay_q      <= '0;
      show_q       <= '0;
      best_q       <= ALL9;
      best_valid_q <= 1'b0;
      disp_q       <= ALL9;
      fs_q         <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_next(lfsr_q);
      shuffle_q    <= {shuffle_q[NUM_LEDS-2:0], shuffle_q[NUM_LEDS-1]};
      led_q        <= led_d;
      delay_q      <= delay_d;
      show_q       <= show_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      disp_q       <= disp_d;
      fs_q         <= fs_d;
      to_q         <= to_d;
    end
  end

`ifdef WRONG_SWITCH_FAULT_EN
  always_ff @(posedge mclk or posedge FSMreset) begin
    if (FSMreset) ws_q <= 1'b0;
    else          ws_q <= ws_d;
  end
  assign wrong_sw = ws_q;
`else
  assign wrong_sw = 1'b0;
`endif

  assign led         = led_q;
  assign disp_bcd    = disp_q;
  assign best_valid  = best_valid_q;
  assign state_o     = state_q;
  assign false_start = fs_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core: a 4-digit main instance plus a 2-digit instance for timeout.
module tb_reaction_timer_core;

  localparam int unsigned NL = 10;

  logic          mclk, FSMreset, tick, start, start2;
  logic [NL-1:0] sw, sw2, led, led2;
  logic [15:0]   disp;
  logic [7:0]    disp2;
  logic          bv, bv2, fs, fs2, to, to2, ws, ws2;
  logic [2:0]    st, st2;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0]   m_lfsr;
  int            shuf_idx;
  logic [NL-1:0] tgt_g;

  reaction_timer_core #(
    .NUM_LEDS(NL), .BCD_DIGITS(4), .DELAY_BITS(2), .MIN_DELAY(5),
    .SHOW_TICKS(4), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .mclk(mclk), .FSMreset(FSMreset), .tick(tick), .start(start), .sw(sw),
    .led(led), .disp_bcd(disp), .best_valid(bv), .state_o(st),
    .false_start(fs), .timeout(to), .wrong_sw(ws)
  );

  reaction_timer_core #(
    .NUM_LEDS(NL), .BCD_DIGITS(2), .DELAY_BITS(2), .MIN_DELAY(5),
    .SHOW_TICKS(4), .LFSR_SEED(16'hACE1)
  ) u_dut2 (
    .mclk(mclk), .FSMreset(FSMreset), .tick(tick), .start(start2), .sw(sw2),
    .led(led2), .disp_bcd(disp2), .best_valid(bv2), .state_o(st2),
    .false_start(fs2), .timeout(to2), .wrong_sw(ws2)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Reference LFSR (x^16+x^14+x^13+x^11, right-shifting) and shuffle position.
  always @(posedge mclk or posedge FSMreset) begin
    if (FSMreset) begin
      m_lfsr   <= 16'hACE1;
      shuf_idx <= 0;
    end else begin
      m_lfsr   <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      shuf_idx <= (shuf_idx == NL - 1) ? 0 : shuf_idx + 1;
    end
  end

  task automatic do_tick();
    tick = 1'b1;
    @(negedge mclk);
    tick = 1'b0;
    @(negedge mclk);
  endtask

  task automatic arm_round(input bit use2, output logic [NL-1:0] tgt);
    int d;
    d = 5 + int'(m_lfsr[1:0]);
    if (use2) start2 = 1'b1;
    else      start  = 1'b1;
    @(negedge mclk);
    start  = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < d - 1; i++) do_tick();
    tgt = '0;
    tgt[shuf_idx] = 1'b1;
    do_tick();
  endtask

  task automatic hit_round(input int n);
    logic [NL-1:0] t;
    arm_round(1'b0, t);
    repeat (n) do_tick();
    sw = t;
    @(negedge mclk);
    sw = '0;
    @(negedge mclk);
  endtask

  task automatic finish_show();
    repeat (4) do_tick();
  endtask

  task automatic test_reset();
    FSMreset = 1'b1;
    start = 1'b0; start2 = 1'b0; tick = 1'b0; sw = '0; sw2 = '0;
    repeat (3) @(negedge mclk);
    n_total++; if (st !== 3'd0) $display("FAIL reset_state: got %0d want 0", st); else n_pass++;
    n_total++; if (led !== '0) $display("FAIL reset_led: got %h want 0", led); else n_pass++;
    n_total++; if (disp !== 16'h9999) $display("FAIL reset_disp: got %h want 9999", disp); else n_pass++;
    n_total++; if (bv !== 1'b0) $display("FAIL reset_best_valid: got %b want 0", bv); else n_pass++;
    n_total++; if ({fs, to, ws} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {fs, to, ws}); else n_pass++;
    n_total++; if (disp2 !== 8'h99) $display("FAIL reset_disp2: got %h want 99", disp2); else n_pass++;
    FSMreset = 1'b0;
    @(negedge mclk);
  endtask

  task automatic test_arm();
    int d;
    d = 5 + int'(m_lfsr[1:0]);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    n_total++; if (st !== 3'd1) $display("FAIL arm_state: got %0d want 1", st); else n_pass++;
    for (int i = 0; i < d - 1; i++) do_tick();
    n_total++; if (st !== 3'd1) $display("FAIL arm_before_last_tick_state: got %0d want 1", st); else n_pass++;
    n_total++; if (led !== '0) $display("FAIL arm_before_last_tick_led: got %h want 0", led); else n_pass++;
    n_total++; if (disp !== 16'h0000) $display("FAIL arm_disp: got %h want 0000", disp); else n_pass++;
    tgt_g = '0;
    tgt_g[shuf_idx] = 1'b1;
    tick = 1'b1;
    @(negedge mclk);
    tick = 1'b0;
    n_total++; if (st !== 3'd2) $display("FAIL arm_timing_state: got %0d want 2", st); else n_pass++;
    n_total++; if (led !== tgt_g) $display("FAIL arm_led_target: got %h want %h", led, tgt_g); else n_pass++;
    @(negedge mclk);
  endtask

  task automatic test_first_hit();
    repeat (123) do_tick();
    n_total++; if (disp !== 16'h0123) $display("FAIL timing_count: got %h want 0123", disp); else n_pass++;
    sw = tgt_g;
    @(negedge mclk);
    sw = '0;
    n_total++; if (st !== 3'd3) $display("FAIL hit_state: got %0d want 3", st); else n_pass++;
    @(negedge mclk);
    n_total++; if (disp !== 16'h0123) $display("FAIL hit_result: got %h want 0123", disp); else n_pass++;
    n_total++; if (led !== '0) $display("FAIL hit_led_off: got %h want 0", led); else n_pass++;
    repeat (3) do_tick();
    n_total++; if (st !== 3'd3) $display("FAIL show_hold: got %0d want 3", st); else n_pass++;
    do_tick();
    n_total++; if (st !== 3'd0) $display("FAIL show_to_idle: got %0d want 0", st); else n_pass++;
    n_total++; if (disp !== 16'h0123) $display("FAIL idle_best: got %h want 0123", disp); else n_pass++;
    n_total++; if (bv !== 1'b1) $display("FAIL best_valid_set: got %b want 1", bv); else n_pass++;
  endtask

  task automatic test_best_tracking();
    hit_round(200);
    n_total++; if (disp !== 16'h0200) $display("FAIL round2_result: got %h want 0200", disp); else n_pass++;
    finish_show();
    n_total++; if (disp !== 16'h0123) $display("FAIL round2_best_kept: got %h want 0123", disp); else n_pass++;
    hit_round(50);
    n_total++; if (disp !== 16'h0050) $display("FAIL round3_result: got %h want 0050", disp); else n_pass++;
    finish_show();
    n_total++; if (disp !== 16'h0050) $display("FAIL round3_best_new: got %h want 0050", disp); else n_pass++;
  endtask

  task automatic test_false_start();
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    do_tick();
    do_tick();
    n_total++; if (st !== 3'd1) $display("FAIL fs_armed: got %0d want 1", st); else n_pass++;
    sw = 10'b00_0000_1000;
    @(negedge mclk);
    sw = '0;
    n_total++; if (st !== 3'd4) $display("FAIL fs_state: got %0d want 4", st); else n_pass++;
    n_total++; if (fs !== 1'b1) $display("FAIL fs_flag: got %b want 1", fs); else n_pass++;
    n_total++; if (led !== '0) $display("FAIL fs_led: got %h want 0", led); else n_pass++;
    @(negedge mclk);
    n_total++; if (disp !== 16'h9999) $display("FAIL fs_disp: got %h want 9999", disp); else n_pass++;
    repeat (3) do_tick();
    n_total++; if (st !== 3'd4) $display("FAIL fs_hold: got %0d want 4", st); else n_pass++;
    do_tick();
    n_total++; if (st !== 3'd0) $display("FAIL fs_to_idle: got %0d want 0", st); else n_pass++;
    n_total++; if (fs !== 1'b1) $display("FAIL fs_persist: got %b want 1", fs); else n_pass++;
    n_total++; if (disp !== 16'h0050) $display("FAIL fs_best_kept: got %h want 0050", disp); else n_pass++;
  endtask

  task automatic test_tick_hit_same();
    logic [NL-1:0] t;
    arm_round(1'b0, t);
    n_total++; if (fs !== 1'b0) $display("FAIL flags_cleared_on_start: got %b want 0", fs); else n_pass++;
    repeat (7) do_tick();
    tick = 1'b1;
    sw = t;
    @(negedge mclk);
    tick = 1'b0;
    sw = '0;
    n_total++; if (st !== 3'd3) $display("FAIL tickhit_state: got %0d want 3", st); else n_pass++;
    @(negedge mclk);
    n_total++; if (disp !== 16'h0007) $display("FAIL tickhit_result: got %h want 0007", disp); else n_pass++;
    finish_show();
    n_total++; if (disp !== 16'h0007) $display("FAIL tickhit_best: got %h want 0007", disp); else n_pass++;
  endtask

  task automatic test_wrong_switch();
    logic [NL-1:0] t, wb;
    arm_round(1'b0, t);
    repeat (3) do_tick();
    wb = t[0] ? NL'(2) : NL'(1);
    sw = wb;
    @(negedge mclk);
`ifdef WRONG_SWITCH_FAULT_EN
    sw = '0;
    n_total++; if (st !== 3'd4) $display("FAIL wrong_state: got %0d want 4", st); else n_pass++;
    n_total++; if (ws !== 1'b1) $display("FAIL wrong_flag: got %b want 1", ws); else n_pass++;
    n_total++; if (led !== '0) $display("FAIL wrong_led: got %h want 0", led); else n_pass++;
    finish_show();
    n_total++; if (st !== 3'd0) $display("FAIL wrong_to_idle: got %0d want 0", st); else n_pass++;
    n_total++; if (disp !== 16'h0007) $display("FAIL wrong_best_kept: got %h want 0007", disp); else n_pass++;
`else
    n_total++; if (st !== 3'd2) $display("FAIL wrong_ignored_state: got %0d want 2", st); else n_pass++;
    n_total++; if (ws !== 1'b0) $display("FAIL wrong_flag_tied: got %b want 0", ws); else n_pass++;
    sw = wb | t;
    @(negedge mclk);
    sw = '0;
    n_total++; if (st !== 3'd3) $display("FAIL wrong_then_hit_state: got %0d want 3", st); else n_pass++;
    @(negedge mclk);
    n_total++; if (disp !== 16'h0003) $display("FAIL wrong_then_hit_result: got %h want 0003", disp); else n_pass++;
    finish_show();
    n_total++; if (disp !== 16'h0003) $display("FAIL wrong_then_hit_best: got %h want 0003", disp); else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    logic [NL-1:0] t;
    arm_round(1'b1, t);
    repeat (99) do_tick();
    n_total++; if (st2 !== 3'd2) $display("FAIL to_still_timing: got %0d want 2", st2); else n_pass++;
    n_total++; if (disp2 !== 8'h99) $display("FAIL to_count_99: got %h want 99", disp2); else n_pass++;
    tick = 1'b1;
    @(negedge mclk);
    tick = 1'b0;
    n_total++; if (st2 !== 3'd3) $display("FAIL to_state: got %0d want 3", st2); else n_pass++;
    n_total++; if (to2 !== 1'b1) $display("FAIL to_flag: got %b want 1", to2); else n_pass++;
    n_total++; if (led2 !== '0) $display("FAIL to_led: got %h want 0", led2); else n_pass++;
    @(negedge mclk);
    n_total++; if (disp2 !== 8'h99) $display("FAIL to_disp: got %h want 99", disp2); else n_pass++;
    finish_show();
    n_total++; if (st2 !== 3'd0) $display("FAIL to_idle: got %0d want 0", st2); else n_pass++;
    n_total++; if (bv2 !== 1'b0) $display("FAIL to_best_not_updated: got %b want 0", bv2); else n_pass++;
    n_total++; if ({fs2, ws2} !== 2'b00) $display("FAIL to_other_flags: got %b want 00", {fs2, ws2}); else n_pass++;
    n_total++; if (st !== 3'd0) $display("FAIL to_main_idle: got %0d want 0", st); else n_pass++;
  endtask

  task automatic test_reset_mid_round();
    logic [NL-1:0] t;
    arm_round(1'b0, t);
    repeat (5) do_tick();
    FSMreset = 1'b1;
    #1;
    n_total++; if (st !== 3'd0) $display("FAIL midreset_state: got %0d want 0", st); else n_pass++;
    n_total++; if (led !== '0) $display("FAIL midreset_led: got %h want 0", led); else n_pass++;
    n_total++; if (bv !== 1'b0) $display("FAIL midreset_best_valid: got %b want 0", bv); else n_pass++;
    @(negedge mclk);
    FSMreset = 1'b0;
    @(negedge mclk);
    n_total++; if (disp !== 16'h9999) $display("FAIL midreset_best_cleared: got %h want 9999", disp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arm();
    test_first_hit();
    test_best_tracking();
    test_false_start();
    test_tick_hit_same();
    test_wrong_switch();
    test_timeout();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
